rr_grant_arbiter8: RTL and testbench
====================================

Name: rr_grant_arbiter8

Overview:
- Round-robin arbiter sharing one 8-way resource between 8 requesters.
- Issues a one-hot grant plus its 3-bit encoded index; the index comes from an internal one-hot-to-binary encoding of the grant.
- The grant is held until the owner signals done, withdraws its request, or exceeds a hold-time limit.
- Sits in front of a shared datapath port; downstream logic muxes on grant_idx.

Parameters:
- N, 8, number of requesters (fixed at 8; the index width depends on it)
- IDX_W, 3, width of grant_idx
- MAX_HOLD, 16, maximum cycles one owner may hold the grant (legal range 2..256)

Ports:
- clk  input  1  clock, all state on rising edge
- resetn  input  1  asynchronous, active-low reset
- req  input  8  request per requester, level-sensitive
- done  input  1  current owner finished; single-cycle pulse, sampled only in OWN
- grant  output  8  one-hot grant, registered; all-zero when no owner
- grant_idx  output  3  binary index of the set grant bit; 0 when grant is all-zero
- grant_valid  output  1  equals |grant
- timeout  output  1  one-cycle pulse: previous owner was revoked by the hold limit

Behaviour:
- Reset (asynchronous, immediate on resetn low): state=IDLE, grant=0, grant_idx=0, grant_valid=0, timeout=0, hold counter=0, last-owner pointer ptr=7 (first search starts at requester 0).
- State IDLE:
  - If req!=0: pick the first set req bit, searching upward from (ptr+1) mod 8 with wrap.
  - Register it into grant/grant_idx and go to OWN.
  - Request sampled at edge t gives grant visible after edge t (latency 1).
  - If req==0: stay in IDLE with grant=0.
  - done is ignored in IDLE.
- State OWN (owner o = grant_idx):
  - The hold counter is 0 in the first OWN cycle and increments each OWN cycle.
  - Release condition: done=1, OR req[o]=0, OR counter==MAX_HOLD-1.
  - On release: next cycle grant=0, state=IDLE, ptr=o, counter=0.
  - timeout=1 in that next cycle only if release was due solely to the counter limit (done=0 and req[o]=1).
  - Otherwise the grant stays unchanged.
  - Changes to other req bits never affect the current grant.
- Release is always followed by exactly one IDLE cycle with grant=0 (bubble). There are no back-to-back grants. A maximum-length hold shows MAX_HOLD consecutive grant cycles.
- Simultaneous done and req[o] drop: a single release, timeout=0.
- done together with the counter limit: treated as a normal release, timeout=0.
- Fairness: with all requests asserted continuously, each requester is granted once per 8 grants, in order ptr+1, ptr+2, ... mod 8.
- A winner that drops req in the same cycle it is granted still holds the grant for one cycle, then releases.
- grant_idx is combinationally encoded from the registered grant (one-hot to binary). grant is guaranteed one-hot or zero.
- Reset mid-operation: the grant drops immediately and asynchronously; the pointer returns to 7.
- The hold counter is clog2(MAX_HOLD) bits wide and never wraps (it clears on release).

Test Plan:
- Reset: resetn=0 with req=8'hFF -> grant=0, grant_idx=0, grant_valid=0, timeout=0. After release, first grant is 8'h01, 1 cycle after the first sampling edge.
- Single requester: req=8'h20, done pulse in the 3rd OWN cycle -> grant=8'h20, grant_idx=5 for 3 cycles, then 1 cycle grant=0. It is re-granted next if req is still high.
- Round robin: req=8'hFF held, done pulsed in every OWN cycle -> grant_idx sequence 0,1,2,...,7,0 with one zero-grant cycle between each; then req=8'h81 with ptr=0 -> next grant_idx=7.
- Timeout: MAX_HOLD=16, req=8'h04 held, no done -> grant=8'h04 for exactly 16 cycles, then grant=0 with timeout=1 for 1 cycle. Requester 2 is then re-granted, since it is the only requester.
- Owner withdraws: owner 3 holds, req[3] drops while other bits stay high -> grant=0 next cycle, timeout=0. Next grant goes to the first set bit above 3 (e.g. req=8'h09 -> idx 0 via wrap).
- Async reset mid-grant: owner 6 in its 5th OWN cycle, resetn pulsed low between edges -> grant=0 immediately without a clock edge. After resetn returns high with req=8'h40, grant=8'h40 on the next edge.

Source files
------------

// File: rtl/rr_grant_arbiter8.sv
// Purpose : round-robin arbiter that hands one shared resource to one of 8 requesters.
// Latency : a request sampled at edge t is granted after edge t; every release costs one idle cycle.
// Backpressure: the owner keeps the grant until it pulses done, drops req, or hits MAX_HOLD cycles.
//
// Ports:
//   clk         - clock, all state on the rising edge
//   resetn      - asynchronous active-low reset
//   req[N]      - level-sensitive request per requester
//   done        - single-cycle pulse from the current owner, sampled only while owning
//   grant[N]    - registered one-hot grant, all-zero when nobody owns the resource
//   grant_idx   - binary index of the set grant bit (0 when grant is all-zero)
//   grant_valid - |grant
//   timeout     - one-cycle pulse: the previous owner was revoked by the hold limit
module rr_grant_arbiter8 #(
    parameter int N        = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [N-1:0]     req,
    input  logic             done,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             timeout
);

    localparam int               CNT_W     = $clog2(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0] PTR_RST   = IDX_W'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     grant_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             timeout_d;

    logic             pick_vld;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] cand;
    logic             owner_req;
    logic             release_own;

    // One-hot to binary: grant is guaranteed one-hot or zero, so OR-ing
    // the indices of the set bits yields the owner index (or 0).
    always_comb begin
        grant_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (grant[k]) begin
                grant_idx = grant_idx | IDX_W'(k);
            end
        end
    end

    assign grant_valid = |grant;

    // Search upward from ptr+1; the 3-bit add wraps naturally, and the
    // last candidate (i == N) is the previous owner itself.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = 1; i <= N; i++) begin
            cand = ptr_q + IDX_W'(i);
            if (!pick_vld && req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign owner_req   = req[grant_idx];
    assign release_own = done | ~owner_req | (hold_q == HOLD_LAST);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    hold_d            = '0;
                    state_d           = OWN;
                end
            end
            OWN: begin
                if (release_own) begin
                    grant_d   = '0;
                    ptr_d     = grant_idx;
                    hold_d    = '0;
                    state_d   = IDLE;
                    // Only a pure hold-limit revocation is flagged; any
                    // release the owner asked for (done or req drop) is not.
                    timeout_d = ~done & owner_req;
                end else begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            grant   <= '0;
            ptr_q   <= PTR_RST;
            hold_q  <= '0;
            timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            grant   <= grant_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            timeout <= timeout_d;
        end
    end

endmodule

// File: tb/tb_rr_grant_arbiter8.sv
// Purpose : directed + randomized bench for rr_grant_arbiter8 against a behavioural owner model.
// Latency : model advances on each rising edge; outputs compared on the following falling edge.
// Backpressure: none; every wait is a bounded cycle loop.
module tb_rr_grant_arbiter8;

    localparam int MAX_HOLD = 16;

    logic       clk    = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] req    = 8'h00;
    logic       done   = 1'b0;
    wire  [7:0] grant;
    wire  [2:0] grant_idx;
    wire        grant_valid;
    wire        timeout;

    rr_grant_arbiter8 #(
        .N        (8),
        .IDX_W    (3),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model: who owns the resource, how many grant cycles it
    // has been visible, and who owned it last.
    int m_owner;
    int m_ptr;
    int m_held;
    bit m_timeout;

    task automatic model_reset();
        m_owner   = -1;
        m_ptr     = 7;
        m_held    = 0;
        m_timeout = 1'b0;
    endtask

    task automatic model_step();
        bit found;
        int c;
        m_timeout = 1'b0;
        if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 1; k <= 8; k++) begin
                c = (m_ptr + k) % 8;
                if (!found && req[c]) begin
                    found   = 1'b1;
                    m_owner = c;
                    m_held  = 1;
                end
            end
        end else begin
            if (done || !req[m_owner] || m_held == MAX_HOLD) begin
                m_timeout = !done && req[m_owner];
                m_ptr     = m_owner;
                m_owner   = -1;
                m_held    = 0;
            end else begin
                m_held = m_held + 1;
            end
        end
    endtask

    task automatic check(input string tag);
        logic [7:0] eg;
        logic [2:0] ei;
        eg = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
        ei = (m_owner < 0) ? 3'd0 : 3'(m_owner);
        checks++;
        assert (grant === eg) else begin
            errors++;
            $error("FAIL %s grant: got %h expected %h", tag, grant, eg);
        end
        checks++;
        assert (grant_idx === ei) else begin
            errors++;
            $error("FAIL %s grant_idx: got %0d expected %0d", tag, grant_idx, ei);
        end
        checks++;
        assert (grant_valid === (eg != 8'h00)) else begin
            errors++;
            $error("FAIL %s grant_valid: got %b expected %b", tag, grant_valid, (eg != 8'h00));
        end
        checks++;
        assert (timeout === m_timeout) else begin
            errors++;
            $error("FAIL %s timeout: got %b expected %b", tag, timeout, m_timeout);
        end
    endtask

    // Explicit check against a value fixed by the scenario itself.
    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check(tag);
    endtask

    initial begin
        int n;
        bit seen_to;

        // Reset with every requester asking.
        model_reset();
        resetn = 1'b0;
        req    = 8'hFF;
        #12;
        check("reset");
        chk("reset_grant", int'(grant), 0);
        @(negedge clk);
        resetn = 1'b1;
        cyc("first");
        chk("first_grant", int'(grant), 8'h01);

        // Round robin: done pulsed in every owning cycle.
        for (int i = 1; i <= 8; i++) begin
            done = 1'b1;
            cyc("rr_rel");
            chk("rr_bubble", int'(grant_valid), 0);
            done = 1'b0;
            cyc("rr_grant");
            chk("rr_order", int'(grant_idx), i % 8);
        end
        // Owner 0 releases with only 0 and 7 requesting: 7 wins.
        done = 1'b1;
        req  = 8'h81;
        cyc("rr81_rel");
        done = 1'b0;
        cyc("rr81_grant");
        chk("rr81_idx", int'(grant_idx), 7);

        // Single requester 5, done in its third owning cycle.
        req = 8'h20;
        cyc("single_rel");
        cyc("single_own1");
        chk("single_idx", int'(grant_idx), 5);
        cyc("single_own2");
        cyc("single_own3");
        chk("single_own3_grant", int'(grant), 8'h20);
        done = 1'b1;
        cyc("single_done");
        chk("single_bubble", int'(grant), 0);
        done = 1'b0;
        cyc("single_regrant");
        chk("single_regrant_grant", int'(grant), 8'h20);

        // Hold limit: requester 2 never signals done.
        req = 8'h04;
        cyc("to_rel");
        cyc("to_own");
        n       = (grant == 8'h04) ? 1 : 0;
        seen_to = 1'b0;
        for (int i = 0; i < 40 && !seen_to; i++) begin
            cyc("to_hold");
            if (grant == 8'h04) n++;
            else seen_to = 1'b1;
        end
        chk("to_hold_cycles", n, MAX_HOLD);
        chk("to_pulse", int'(timeout), 1);
        cyc("to_regrant");
        chk("to_regrant_grant", int'(grant), 8'h04);
        chk("to_pulse_clear", int'(timeout), 0);

        // Owner 3 withdraws while others keep requesting.
        req = 8'h08;
        cyc("wd_rel");
        req = 8'h0F;
        cyc("wd_own1");
        chk("wd_owner", int'(grant_idx), 3);
        cyc("wd_own2");
        req = 8'h07;
        cyc("wd_drop");
        chk("wd_no_timeout", int'(timeout), 0);
        req = 8'h09;
        cyc("wd_next");
        chk("wd_wrap_idx", int'(grant_idx), 0);

        // Asynchronous reset while owner 6 is in its fifth owning cycle.
        req = 8'h40;
        cyc("ar_rel");
        for (int i = 1; i <= 5; i++) cyc("ar_own");
        chk("ar_owner", int'(grant), 8'h40);
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check("ar_async");
        chk("ar_grant_zero", int'(grant), 0);
        resetn = 1'b1;
        cyc("ar_after");
        chk("ar_after_grant", int'(grant), 8'h40);

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 3))
                    0:       req = 8'hFF;
                    1:       req = 8'(1 << $urandom_range(0, 7));
                    default: req = 8'($urandom & $urandom);
                endcase
            end
            done = ($urandom_range(0, 11) == 0);
            cyc("rand");
        end
        done = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
